// File: rtl/keypad_pkg.sv
// Shared types and decode helpers for the keypad event path.
// Nibble encodings follow the scanner's one-hot row/column convention.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      QUALIFY,
      HELD
   } state_t;

   localparam logic [3:0] ROW0 = 4'b1000;
   localparam logic [3:0] ROW1 = 4'b0100;
   localparam logic [3:0] ROW2 = 4'b0010;
   localparam logic [3:0] ROW3 = 4'b0001;
   localparam logic [3:0] COL0 = 4'b1000;
   localparam logic [3:0] COL1 = 4'b0100;
   localparam logic [3:0] COL2 = 4'b0010;
   localparam logic [3:0] COL3 = 4'b0001;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } idx_t;

   // Rows and columns share encodings, so one decoder serves both nibbles.
   function automatic idx_t onehot4_to_idx(input logic [3:0] nib);
      idx_t r;
      r = '0;
      case (nib)
         ROW0:    r = '{valid: 1'b1, idx: 2'd0};
         ROW1:    r = '{valid: 1'b1, idx: 2'd1};
         ROW2:    r = '{valid: 1'b1, idx: 2'd2};
         ROW3:    r = '{valid: 1'b1, idx: 2'd3};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through FIFO for decoded key events, with sticky overflow.
// Pointers carry one extra bit so full and empty are distinguishable.
module key_event_fifo
   import keypad_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     overflow_clr,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             pop_ok;
   logic             push_ok;
   logic             drop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign drop    = push && full && !pop_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/keycode_event_queue.sv
// Debounces scanner keycodes into single press events and queues their
// decoded key indices for a valid/ready consumer.
module keycode_event_queue
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [7:0]                    keycode,
   input  logic                          keyValid,
   output logic                          evt_valid,
   output logic [3:0]                    evt_key,
   input  logic                          evt_ready,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          bad_code,
   output logic                          overflow,
   input  logic                          overflow_clr
);

   localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic [7:0] code_q, code_n;
   logic       qualify;
   logic       code_ok;
   logic       push;
   idx_t       row_d;
   idx_t       col_d;
   logic [3:0] key_idx;
   logic       fifo_full;
   logic       fifo_empty;

   assign row_d   = onehot4_to_idx(code_q[3:0]);
   assign col_d   = onehot4_to_idx(code_q[7:4]);
   assign key_idx = {row_d.idx, col_d.idx};
   assign code_ok = row_d.valid && col_d.valid;
   assign push    = qualify && code_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         code_q   <= '0;
         bad_code <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         code_q   <= code_n;
         bad_code <= qualify && !code_ok;
      end
   end

   // In HELD, cnt counts consecutive released samples rather than matches.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      code_n  = code_q;
      qualify = 1'b0;
      case (state)
         IDLE: begin
            if (keyValid) begin
               code_n  = keycode;
               cnt_n   = 8'd1;
               state_n = QUALIFY;
            end
         end
         QUALIFY: begin
            if (keyValid && (keycode == code_q)) begin
               if (cnt == LAST) begin
                  qualify = 1'b1;
                  cnt_n   = '0;
                  state_n = HELD;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end else begin
               cnt_n   = '0;
               state_n = IDLE;
            end
         end
         HELD: begin
            if (keyValid) begin
               cnt_n = '0;
            end else if (cnt == LAST) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (4)
   ) u_fifo (
      .clk          (clk),
      .reset_n      (reset_n),
      .push         (push),
      .push_data    (key_idx),
      .pop          (evt_ready),
      .overflow_clr (overflow_clr),
      .rd_data      (evt_key),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .count        (evt_count),
      .overflow     (overflow)
   );

   assign evt_valid = !fifo_empty;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Scoreboard bench for keycode_event_queue: stimulus enqueues expected keys,
// a negedge monitor compares each accepted head entry against them.
module tb_keycode_event_queue;

   localparam int N = 4;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] keycode = '0;
   logic       keyValid = 1'b0;
   logic       evt_ready = 1'b0;
   logic       overflow_clr = 1'b0;
   logic       evt_valid;
   logic [3:0] evt_key;
   logic [2:0] evt_count;
   logic       bad_code;
   logic       overflow;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] sb[$];
   logic [3:0] mon_exp;

   keycode_event_queue #(
      .DEBOUNCE_CYCLES (N),
      .FIFO_DEPTH      (D)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .keycode      (keycode),
      .keyValid     (keyValid),
      .evt_valid    (evt_valid),
      .evt_key      (evt_key),
      .evt_ready    (evt_ready),
      .evt_count    (evt_count),
      .bad_code     (bad_code),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One sample: value presented for the next rising edge, returns 1ns after it.
   task automatic drive(input logic kv, input logic [7:0] code);
      keyValid = kv;
      keycode  = code;
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] code, input int hi);
      for (int i = 0; i < hi; i++) drive(1'b1, code);
      for (int i = 0; i < N; i++) drive(1'b0, 8'h00);
   endtask

   task automatic drain();
      evt_ready = 1'b1;
      for (int i = 0; i < 20 && evt_count != 0; i++) begin
         @(posedge clk);
         #1;
      end
      evt_ready = 1'b0;
      chk("drain_empty", evt_count, 0);
   endtask

   always @(negedge clk) begin
      if (reset_n && evt_valid && evt_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_pop", {28'd0, evt_key}, 32'hFFFF_FFFF);
         end else begin
            mon_exp = sb.pop_front();
            chk("pop_key", {28'd0, evt_key}, {28'd0, mon_exp});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #23 reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_valid", evt_valid, 0);
      chk("rst_key", evt_key, 0);
      chk("rst_count", evt_count, 0);
      chk("rst_bad", bad_code, 0);
      chk("rst_ovf", overflow, 0);

      // Clean press of 8'h48 -> key 1, valid from the 4th sample edge on
      sb.push_back(4'd1);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 8'h48);
         chk("clean_valid", evt_valid, (i >= 3) ? 1 : 0);
      end
      for (int i = 0; i < 6; i++) drive(1'b0, 8'h00);
      chk("clean_count", evt_count, 1);
      drain();

      // Bounce 1,1,0,1,1,1,1 with 8'h81 -> key 12 only after 4th consecutive
      drive(1'b1, 8'h81);
      drive(1'b1, 8'h81);
      drive(1'b0, 8'h00);
      drive(1'b1, 8'h81);
      drive(1'b1, 8'h81);
      drive(1'b1, 8'h81);
      chk("bounce_none", evt_count, 0);
      sb.push_back(4'd12);
      drive(1'b1, 8'h81);
      chk("bounce_one", evt_count, 1);
      for (int i = 0; i < N; i++) drive(1'b0, 8'h00);
      drain();

      // Bad code 8'hC1 -> single bad_code pulse after the qualifying edge
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'hC1);
         chk("bad_pulse", bad_code, (i == 3) ? 1 : 0);
      end
      for (int i = 0; i < N; i++) drive(1'b0, 8'h00);
      chk("bad_count", evt_count, 0);

      // Overflow: five presses, fifth dropped
      sb.push_back(4'd3);
      sb.push_back(4'd6);
      sb.push_back(4'd9);
      sb.push_back(4'd12);
      press(8'h18, N);
      press(8'h24, N);
      press(8'h42, N);
      press(8'h81, N);
      chk("ovf_pre", overflow, 0);
      press(8'h11, N);
      chk("ovf_count", evt_count, 4);
      chk("ovf_set", overflow, 1);
      drain();
      chk("ovf_sticky", overflow, 1);
      overflow_clr = 1'b1;
      drive(1'b0, 8'h00);
      overflow_clr = 1'b0;
      chk("ovf_clr", overflow, 0);

      // Full FIFO: push and pop on the same edge
      sb.push_back(4'd3);
      sb.push_back(4'd6);
      sb.push_back(4'd9);
      sb.push_back(4'd12);
      press(8'h18, N);
      press(8'h24, N);
      press(8'h42, N);
      press(8'h81, N);
      chk("full_count", evt_count, 4);
      for (int i = 0; i < N - 1; i++) drive(1'b1, 8'h11);
      evt_ready = 1'b1;
      sb.push_back(4'd15);
      drive(1'b1, 8'h11);
      evt_ready = 1'b0;
      chk("pp_count", evt_count, 4);
      chk("pp_ovf", overflow, 0);
      for (int i = 0; i < N; i++) drive(1'b0, 8'h00);
      drain();

      // Reset during QUALIFY with two entries queued
      press(8'h18, N);
      press(8'h24, N);
      chk("mid_count", evt_count, 2);
      drive(1'b1, 8'h48);
      drive(1'b1, 8'h48);
      #2 reset_n = 1'b0;
      sb.delete();
      #1;
      chk("mid_valid", evt_valid, 0);
      chk("mid_key", evt_key, 0);
      chk("mid_cnt0", evt_count, 0);
      chk("mid_bad", bad_code, 0);
      chk("mid_ovf", overflow, 0);
      keyValid = 1'b0;
      @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_count", evt_count, 0);
      sb.push_back(4'd1);
      press(8'h48, N);
      chk("post_rst_press", evt_count, 1);
      drain();

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keycode_event_queue.md
# keycode_event_queue

Downstream consumer of the 4x4 keypad scanner. Takes the scanner's raw `keycode` ({col, row} one-hot nibbles) and `keyValid` level and debounces them into exactly one press event per physical keypress. Each event is decoded to a 4-bit key index and buffered in a small FIFO that software-side logic drains through a valid/ready handshake.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- `DEBOUNCE_CYCLES`, default 4. Number of consecutive matching samples needed to qualify a press, and also a release. Legal range 2..255.
- `FIFO_DEPTH`, default 4. Event queue depth. Must be a power of 2, at least 2.

Ports:
- `clk` input, 1 bit. Rising-edge clock, same clock as the scanner.
- `reset_n` input, 1 bit. Asynchronous active-low reset.
- `keycode` input, 8 bits. Scanner output; [7:4] is the one-hot column, [3:0] is the one-hot row.
- `keyValid` input, 1 bit. Scanner level; high while a key is seen.
- `evt_valid` output, 1 bit. FIFO not empty.
- `evt_key` output, 4 bits. Head-of-queue key index.
- `evt_ready` input, 1 bit. Consumer accepts the head entry.
- `evt_count` output, clog2(FIFO_DEPTH)+1 bits. Current occupancy.
- `bad_code` output, 1 bit. One-cycle pulse when a qualified code is not one-hot in both nibbles.
- `overflow` output, 1 bit. Sticky flag; set when a qualified event is dropped because the FIFO is full.
- `overflow_clr` input, 1 bit. Synchronous clear for `overflow`.

## Operation
- Index decode:
  - Row nibble maps 1000→0, 0100→1, 0010→2, 0001→3.
  - Column nibble [7:4] uses the same mapping.
  - `evt_key` = row_idx*4 + col_idx. Example: keycode 8'h48 (col 0100, row 1000) gives index 1.
- FSM states: IDLE, QUALIFY, HELD. All 8-bit counters.
  - IDLE: on a sample with `keyValid`=1, latch `keycode`, set cnt=1, go to QUALIFY.
  - QUALIFY: on a sample with `keyValid`=1 and `keycode` equal to the latched code, cnt++.
    - When a matching sample arrives with cnt==DEBOUNCE_CYCLES-1, the code is qualified and the FSM goes to HELD.
    - On qualification, a one-hot code is pushed to the FIFO. A non-one-hot code pulses `bad_code` and is not pushed.
    - `keyValid`=0 or a code mismatch returns to IDLE with no event.
  - HELD: count consecutive `keyValid`=0 samples; any `keyValid`=1 resets the count to 0.
    - After DEBOUNCE_CYCLES consecutive low samples, go to IDLE.
    - Code changes while held are ignored, so a second key gives no event until release.
- FIFO behaviour:
  - First-word fall-through: `evt_key` is valid whenever `evt_valid`=1.
  - Pop occurs when `evt_valid && evt_ready`.
  - `evt_ready` while empty is ignored.
- Boundary conditions:
  - Push while full with no pop: event dropped, `overflow` set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push into an empty FIFO: no bypass; `evt_valid` rises the cycle after the push edge.
  - Pointers wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
  - `overflow_clr` and a new overflow in the same cycle: set wins.
- Reset values (asynchronous, any time, including mid-qualify):
  - State IDLE; counters and pointers 0.
  - `evt_valid`=0, `evt_key`=0, `evt_count`=0, `bad_code`=0, `overflow`=0.
  - Queued events are discarded.

## Timing
- Press latency: with the first `keyValid`=1 sample at edge 0 and matching samples at edges 1..N-1 (N=DEBOUNCE_CYCLES), the push happens at edge N-1. `evt_valid`=1 is visible from edge N-1 onward, i.e. N-1 cycles after entry to QUALIFY.
- `bad_code` is high for exactly the cycle following the qualifying edge.
- Pop at edge k: the next entry, or `evt_valid`=0, appears after edge k. `evt_count` updates on the same edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state enum (IDLE, QUALIFY, HELD);
  - one-hot nibble constants ROW0..ROW3 / COL0..COL3;
  - a onehot4_to_idx function returning the index plus a valid bit.
- Sub-module `key_event_fifo`: parameterised FWFT synchronous FIFO with push, pop, full, empty, count and `overflow`. The top level contains the FSM, counters and decode.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and FIFO_DEPTH=4.
- Clean press: `keycode`=8'h48, `keyValid`=1 for 10 cycles, then 0 for 6 → exactly one event, `evt_key`=1, `evt_valid` rising 3 cycles after the first sample; no second event.
- Bounce: `keyValid` pattern 1,1,0,1,1,1,1 with code 8'h81 → no event from the first burst; one event with `evt_key`=12 after the 4th consecutive sample.
- Bad code: `keycode`=8'hC1 (two columns) held for 6 cycles → one `bad_code` pulse, `evt_count` stays 0.
- Overflow: 5 qualified presses with `evt_ready`=0 → `evt_count`=4 and `overflow`=1. Draining returns the first four indices in order. `overflow_clr` then clears the flag.
- Full push/pop: FIFO full, qualifying press completes in the same cycle as `evt_ready`=1 → count stays 4, `overflow`=0, and the new key ends up at the tail.
- Reset mid-operation: assert `reset_n`=0 during QUALIFY and with 2 entries queued → all outputs 0 immediately; a press after release yields a normal single event.
